// File: rtl/system_interconnect_if.sv
// system_interconnect_if: leader/follower bus bundle (interface bus) shared by the CPU side and every follower
interface bus #(
  parameter int AddrWidth = 32
);
  logic [AddrWidth-1:0] addr;
  logic [31:0]          write_data;
  logic [3:0]           byte_enable;
  logic                 read_req;
  logic                 write_req;
  logic [31:0]          read_data;
  logic                 read_data_valid;

  modport leader (
    output addr, write_data, byte_enable, read_req, write_req,
    input  read_data, read_data_valid
  );

  modport follower (
    input  addr, write_data, byte_enable, read_req, write_req,
    output read_data, read_data_valid
  );
endinterface

// File: rtl/system_interconnect.sv
// system_interconnect: single-leader to N-follower fabric with tag decode, one outstanding read and error responses; SYSTEM_INTERCONNECT_TIMEOUT_EN adds a read watchdog
module system_interconnect #(
  parameter int          Followers     = 4,
  parameter int          AddrWidth     = 32,
  parameter int          TagWidth      = 4,
  parameter int          TimeoutCycles = 255,
  parameter logic [31:0] ErrorData     = 32'hBADB_AD00
) (
  input  logic clk,
  input  logic rst_n,
  bus.follower leader,
  bus.leader   followers [Followers],
  output logic busy,
  output logic error
);
  localparam int Slots = 2 ** TagWidth;

  typedef enum logic [1:0] {IDLE, WAIT, ERR_RESP} state_t;

  state_t               state_q;
  logic [TagWidth-1:0]  pend_tag_q;
  logic                 error_q;
  logic                 error_d;
  logic [TagWidth-1:0]  tag;
  logic                 mapped;
  logic                 idle;
  logic                 rd_fwd;
  logic                 wr_fwd;
  logic                 rsp_valid;
  logic                 timeout;
  logic [AddrWidth-1:0] fwd_addr;
  logic [31:0]          rsp_data [Slots];
  logic                 rsp_vld  [Slots];

  assign tag      = leader.addr[AddrWidth-1 -: TagWidth];
  assign mapped   = int'(tag) < Followers;
  assign idle     = state_q == IDLE;
  assign fwd_addr = {{TagWidth{1'b0}}, leader.addr[AddrWidth-TagWidth-1:0]};
  assign rd_fwd   = rst_n && leader.read_req && mapped && idle;
  assign wr_fwd   = rst_n && leader.write_req && mapped;

  // Unused tag slots read back as silent followers so pend_tag indexing is always in range
  for (genvar i = 0; i < Slots; i++) begin : g_slot
    if (i < Followers) begin : g_map
      assign followers[i].addr        = fwd_addr;
      assign followers[i].write_data  = leader.write_data;
      assign followers[i].byte_enable = leader.byte_enable;
      assign followers[i].read_req    = rd_fwd && tag == TagWidth'(i);
      assign followers[i].write_req   = wr_fwd && tag == TagWidth'(i);
      assign rsp_data[i]              = followers[i].read_data;
      assign rsp_vld[i]               = followers[i].read_data_valid;
    end else begin : g_unmap
      assign rsp_data[i] = '0;
      assign rsp_vld[i]  = 1'b0;
    end
  end

  assign rsp_valid              = state_q == WAIT && rsp_vld[pend_tag_q];
  assign leader.read_data_valid = rsp_valid || state_q == ERR_RESP;
  assign leader.read_data       = rsp_valid ? rsp_data[pend_tag_q] : state_q == ERR_RESP ? ErrorData : '0;
  assign busy                   = !idle;
  assign error                  = error_q;
  assign error_d                = (leader.read_req && !(mapped && idle)) || (leader.write_req && !mapped) || timeout;

`ifdef SYSTEM_INTERCONNECT_TIMEOUT_EN
  logic [15:0] timer_q;

  assign timeout = state_q == WAIT && !rsp_valid && timer_q == 16'(TimeoutCycles - 1);

  // Count WAIT cycles without a response, restarting on each forwarded read
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) timer_q <= '0;
    else if (rd_fwd) timer_q <= '0;
    else if (state_q == WAIT && !rsp_valid) timer_q <= timer_q + 16'd1;
`else
  assign timeout = 1'b0;
`endif

  // Read tracking FSM: latch the tag of a forwarded read, return one error beat for unmapped or timed-out reads
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q    <= IDLE;
      pend_tag_q <= '0;
      error_q    <= 1'b0;
    end else begin
      error_q    <= error_d;
      pend_tag_q <= rd_fwd ? tag : pend_tag_q;
      state_q    <= idle ? (leader.read_req ? (mapped ? WAIT : ERR_RESP) : IDLE) :
                    state_q == WAIT ? (rsp_valid ? IDLE : timeout ? ERR_RESP : WAIT) : IDLE;
    end
endmodule

// File: tb/tb_system_interconnect.sv
// tb_system_interconnect: table vectors, directed corner sequences and a randomized run against a transaction-level model
module tb_system_interconnect;
  localparam int          F     = 4;
  localparam int          AW    = 32;
  localparam int          TW    = 4;
  localparam int          TO    = 8;
  localparam logic [31:0] ED    = 32'hBADB_AD00;
  localparam logic [31:0] AMASK = 32'h0FFF_FFFF;
`ifdef SYSTEM_INTERCONNECT_TIMEOUT_EN
  localparam bit TMO = 1'b1;
`else
  localparam bit TMO = 1'b0;
`endif

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wd;
    logic [3:0]  be;
    logic [3:0]  wmask;
    logic [31:0] faddr;
    logic        err;
  } wvec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        busy, error;
  logic [31:0] f_rd [F];
  logic        f_rv [F];
  logic [F-1:0] o_rr, o_wr;
  logic [31:0] o_addr [F];
  logic [31:0] o_wd [F];
  logic [3:0]  o_be [F];
  int          total = 0;
  int          bad = 0;

  bus #(.AddrWidth(AW)) lb ();
  bus #(.AddrWidth(AW)) fb [F] ();

  always #5 clk = ~clk;

  for (genvar g = 0; g < F; g++) begin : g_f
    assign fb[g].read_data       = f_rd[g];
    assign fb[g].read_data_valid = f_rv[g];
    assign o_rr[g]               = fb[g].read_req;
    assign o_wr[g]               = fb[g].write_req;
    assign o_addr[g]             = fb[g].addr;
    assign o_wd[g]               = fb[g].write_data;
    assign o_be[g]               = fb[g].byte_enable;
  end

  system_interconnect #(
    .Followers(F), .AddrWidth(AW), .TagWidth(TW), .TimeoutCycles(TO), .ErrorData(ED)
  ) dut (
    .clk(clk), .rst_n(rst_n), .leader(lb), .followers(fb), .busy(busy), .error(error)
  );

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", n, act, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic [31:0] a, input logic r, input logic w,
                     input logic [31:0] d, input logic [3:0] b);
    lb.addr        = a;
    lb.read_req    = r;
    lb.write_req   = w;
    lb.write_data  = d;
    lb.byte_enable = b;
  endtask

  task automatic fclr();
    for (int i = 0; i < F; i++) begin
      f_rv[i] = 1'b0;
      f_rd[i] = 32'h0;
    end
  endtask

  initial begin
    wvec_t wv [5];
    wv = '{
      '{32'h1000_0004, 32'hCAFE_F00D, 4'b0011, 4'b0010, 32'h0000_0004, 1'b0},
      '{32'h0123_4568, 32'h1111_2222, 4'b1111, 4'b0001, 32'h0123_4568, 1'b0},
      '{32'h3FFF_FFFC, 32'h3333_4444, 4'b1000, 4'b1000, 32'h0FFF_FFFC, 1'b0},
      '{32'h4000_0000, 32'h5555_6666, 4'b0001, 4'b0000, 32'h0000_0000, 1'b1},
      '{32'hF000_0008, 32'h7777_8888, 4'b0100, 4'b0000, 32'h0000_0008, 1'b1}
    };
    fclr();
    drv(32'h1000_0000, 1'b1, 1'b1, 32'h0, 4'h0);
    #3;
    chk("rst_busy", busy, 0);
    chk("rst_err", error, 0);
    chk("rst_rdv", lb.read_data_valid, 0);
    chk("rst_rd", lb.read_data, 0);
    chk("rst_req", {o_rr, o_wr}, 0);
    nxt();
    rst_n = 1'b1;
    drv(0, 0, 0, 0, 0);
    nxt();

    foreach (wv[k]) begin
      drv(wv[k].addr, 1'b0, 1'b1, wv[k].wd, wv[k].be);
      #3;
      chk("wr_mask", o_wr, wv[k].wmask);
      chk("wr_rr", o_rr, 0);
      chk("wr_addr", o_addr[0], wv[k].faddr);
      chk("wr_data", o_wd[3], wv[k].wd);
      chk("wr_be", o_be[1], wv[k].be);
      nxt();
      drv(0, 0, 0, 0, 0);
      #3;
      chk("wr_err", error, wv[k].err);
      nxt();
    end

    drv(32'h2000_0010, 1'b1, 1'b0, 0, 0);
    #3;
    chk("rd_rr", o_rr, 4'b0100);
    chk("rd_addr", o_addr[2], 32'h0000_0010);
    chk("rd_busy0", busy, 0);
    nxt();
    drv(0, 0, 0, 0, 0);
    for (int c = 1; c <= 3; c++) begin
      if (c == 3) begin
        f_rv[2] = 1'b1;
        f_rd[2] = 32'h1234_5678;
      end
      #3;
      chk("rd_busy", busy, 1);
      chk("rd_rdv", lb.read_data_valid, 32'(c == 3));
      chk("rd_data", lb.read_data, c == 3 ? 32'h1234_5678 : 32'h0);
      nxt();
    end
    fclr();
    #3;
    chk("rd_busy4", busy, 0);
    chk("rd_rdv4", lb.read_data_valid, 0);
    nxt();

    drv(32'hF000_0000, 1'b1, 1'b0, 0, 0);
    #3;
    chk("um_req", {o_rr, o_wr}, 0);
    nxt();
    drv(0, 0, 0, 0, 0);
    #3;
    chk("um_err", error, 1);
    chk("um_rdv", lb.read_data_valid, 1);
    chk("um_rd", lb.read_data, ED);
    chk("um_busy", busy, 1);
    nxt();
    #3;
    chk("um_err2", error, 0);
    chk("um_rdv2", lb.read_data_valid, 0);
    chk("um_busy2", busy, 0);
    nxt();

    drv(32'h0000_0040, 1'b1, 1'b0, 0, 0);
    #3;
    chk("sp_rr", o_rr, 4'b0001);
    nxt();
    drv(0, 0, 0, 0, 0);
    f_rv[1] = 1'b1;
    f_rd[1] = 32'hDEAD_0001;
    #3;
    chk("sp_ign", lb.read_data_valid, 0);
    chk("sp_ignd", lb.read_data, 0);
    nxt();
    f_rv[1] = 1'b0;
    f_rv[0] = 1'b1;
    f_rd[0] = 32'hA5A5_0001;
    #3;
    chk("sp_rdv", lb.read_data_valid, 1);
    chk("sp_rd", lb.read_data, 32'hA5A5_0001);
    nxt();
    fclr();
    #3;
    chk("sp_busy", busy, 0);
    nxt();

`ifdef SYSTEM_INTERCONNECT_TIMEOUT_EN
    drv(32'h3000_0000, 1'b1, 1'b0, 0, 0);
    nxt();
    drv(0, 0, 0, 0, 0);
    for (int c = 1; c <= 12; c++) begin
      if (c == 12) begin
        f_rv[3] = 1'b1;
        f_rd[3] = 32'h7777_0000;
      end
      #3;
      chk("to_err", error, 32'(c == 9));
      chk("to_rdv", lb.read_data_valid, 32'(c == 9));
      chk("to_rd", lb.read_data, c == 9 ? ED : 32'h0);
      chk("to_busy", busy, 32'(c <= 9));
      nxt();
    end
    fclr();
`endif

    drv(32'h1000_0000, 1'b1, 1'b0, 0, 0);
    nxt();
    drv(0, 0, 0, 0, 0);
    #3;
    chk("rm_busy", busy, 1);
    nxt();
    rst_n = 1'b0;
    drv(32'h1000_0000, 1'b1, 1'b1, 0, 0);
    f_rv[1] = 1'b1;
    f_rd[1] = 32'h5555_AAAA;
    #3;
    chk("rm_busy0", busy, 0);
    chk("rm_err0", error, 0);
    chk("rm_rdv0", lb.read_data_valid, 0);
    chk("rm_rd0", lb.read_data, 0);
    chk("rm_req0", {o_rr, o_wr}, 0);
    nxt();
    rst_n = 1'b1;
    drv(0, 0, 0, 0, 0);
    #3;
    chk("rm_ign", lb.read_data_valid, 0);
    chk("rm_busy1", busy, 0);
    nxt();
    fclr();
    nxt();

    begin
      bit outst, errresp, errpulse;
      int ptag, waited;
      outst = 0;
      errresp = 0;
      errpulse = 0;
      ptag = 0;
      waited = 0;
      for (int n = 0; n < 2000; n++) begin
        logic [31:0] a, ed;
        int tg;
        bit rr, wr, mp, idl, tmo, rv;
        tg = $urandom_range(0, 7);
        a = {tg[3:0], 28'($urandom)};
        rr = $urandom_range(0, 3) == 0;
        wr = $urandom_range(0, 3) == 0;
        drv(a, rr, wr, $urandom, 4'($urandom));
        for (int i = 0; i < F; i++) begin
          f_rv[i] = $urandom_range(0, 2) == 0;
          f_rd[i] = $urandom;
        end
        #3;
        mp  = tg < F;
        idl = !outst && !errresp;
        rv  = outst && f_rv[ptag];
        tmo = TMO && outst && !rv && waited == TO - 1;
        ed  = rv ? f_rd[ptag] : errresp ? ED : 32'h0;
        chk("m_rr", o_rr, (rr && mp && idl) ? 32'(1 << tg) : 32'h0);
        chk("m_wr", o_wr, (wr && mp) ? 32'(1 << tg) : 32'h0);
        chk("m_rdv", lb.read_data_valid, 32'(rv || errresp));
        chk("m_rd", lb.read_data, ed);
        chk("m_busy", busy, 32'(outst || errresp));
        chk("m_err", error, 32'(errpulse));
        chk("m_addr", o_addr[n % F], a & AMASK);
        errpulse = (rr && !(mp && idl)) || (wr && !mp) || tmo;
        if (idl) begin
          if (rr && mp) begin
            outst = 1;
            ptag = tg;
            waited = 0;
          end else if (rr) errresp = 1;
        end else if (errresp) errresp = 0;
        else if (rv) outst = 0;
        else if (tmo) begin
          outst = 0;
          errresp = 1;
        end else waited++;
        nxt();
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
